fp_mul_seq: RTL and testbench

- Parametrised, multi-cycle IEEE-754 multiplier for the multicycle datapath; defaults give single precision.
- The significand product is formed by a radix-2 shift-add engine, one bit per cycle, followed by one normalise/round cycle.
- Adds to the earlier combinational unit: round-to-nearest-even, zero/Inf/NaN handling, overflow/underflow detection, exception flags and a start/done handshake.

---
 rtl/fp_mul_seq_if.sv | 28 ++
 rtl/fp_mul_seq.sv | 171 +++++++++++++++++
 tb/tb_fp_mul_seq.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_seq_if.sv
// Start/done request bus for the sequential IEEE-754 multiplier.
// The requester drives the operands and start; the multiplier returns status, result and flags.
interface fp_mul_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         flag_ovf;
  logic         flag_unf;
  logic         flag_inv;

  modport master (
    output start, a, b,
    input  busy, done, result, flag_ovf, flag_unf, flag_inv
  );

  modport slave (
    input  start, a, b,
    output busy, done, result, flag_ovf, flag_unf, flag_inv
  );
endinterface

// File: rtl/fp_mul_seq.sv
// Multi-cycle IEEE-754 multiplier: M cycles of radix-2 shift-add, then one normalise/round cycle.
// done pulses MAN_W+2 edges after start is accepted; start is ignored while busy.
module fp_mul_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic          clk,
  input  logic          reset,
  fp_mul_seq_if.slave   bus
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int M    = MAN_W + 1;
  localparam int CW   = $clog2(M);
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam logic signed [EXP_W+1:0] E_MAX  = (EXP_W+2)'(EMAX);
  localparam logic        [W-1:0]     QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, NORM} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [M-1:0]     mplier_q, mplier_d;
  logic [2*M-1:0]   mcand_q, mcand_d;
  logic [2*M-1:0]   acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     res_q, res_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d, done_q, done_d;

  // Classification and rounding of the captured operands and finished product.
  logic [EXP_W-1:0]        exp_a, exp_b;
  logic                    zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, sign;
  logic [MAN_W-1:0]        frac;
  logic                    guard, sticky, norm, rnd;
  logic [MAN_W:0]          frac_sum;
  logic signed [EXP_W+1:0] e;
  logic [W-1:0]            fin_res;
  logic                    fin_ovf, fin_unf, fin_inv;

  always_comb begin
    exp_a  = a_q[W-2:MAN_W];
    exp_b  = b_q[W-2:MAN_W];
    zero_a = (exp_a == '0);
    zero_b = (exp_b == '0);
    inf_a  = (&exp_a) && (a_q[MAN_W-1:0] == '0);
    inf_b  = (&exp_b) && (b_q[MAN_W-1:0] == '0);
    nan_a  = (&exp_a) && (a_q[MAN_W-1:0] != '0);
    nan_b  = (&exp_b) && (b_q[MAN_W-1:0] != '0);
    sign   = a_q[W-1] ^ b_q[W-1];

    norm = acc_q[2*M-1];
    if (norm) begin
      frac   = acc_q[2*M-2:M];
      guard  = acc_q[M-1];
      sticky = |acc_q[M-2:0];
    end else begin
      frac   = acc_q[2*M-3:M-1];
      guard  = acc_q[M-2];
      sticky = |acc_q[M-3:0];
    end
    rnd      = guard & (sticky | frac[0]);
    frac_sum = {1'b0, frac} + (MAN_W+1)'(rnd);
    e        = (EXP_W+2)'(exp_a) + (EXP_W+2)'(exp_b) - (EXP_W+2)'(BIAS)
             + (EXP_W+2)'(norm) + (EXP_W+2)'(frac_sum[MAN_W]);

    fin_ovf = 1'b0;
    fin_unf = 1'b0;
    fin_inv = 1'b0;
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
      fin_res = QNAN;
      fin_inv = 1'b1;
    end else if (inf_a || inf_b) begin
      fin_res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero_a || zero_b) begin
      fin_res = {sign, {(W-1){1'b0}}};
    end else if (e >= E_MAX) begin
      fin_res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      fin_ovf = 1'b1;
    end else if (e <= 0) begin
      fin_res = {sign, {(W-1){1'b0}}};
      fin_unf = 1'b1;
    end else begin
      fin_res = {sign, e[EXP_W-1:0], frac_sum[MAN_W-1:0]};
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    inv_d    = inv_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = MUL;
          a_d      = bus.a;
          b_d      = bus.b;
          mcand_d  = {{M{1'b0}}, 1'b1, bus.a[MAN_W-1:0]};
          mplier_d = {1'b1, bus.b[MAN_W-1:0]};
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      MUL: begin
        // Shifting the multiplicand each cycle is equivalent to adding it shifted by count.
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mplier_d = mplier_q >> 1;
        mcand_d  = mcand_q << 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(M - 1)) state_d = NORM;
      end
      NORM: begin
        state_d = IDLE;
        res_d   = fin_res;
        ovf_d   = fin_ovf;
        unf_d   = fin_unf;
        inv_d   = fin_inv;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inv_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      inv_q    <= inv_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.result   = res_q;
  assign bus.flag_ovf = ovf_q;
  assign bus.flag_unf = unf_q;
  assign bus.flag_inv = inv_q;
endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed and randomized checks of fp_mul_seq (single precision) against an arithmetic reference model.
module tb_fp_mul_seq;
  localparam int LAT = 25;
  localparam int LIM = 60;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  fp_mul_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_mul_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {ovf, unf, inv, result}; rounding uses remainder-vs-half comparison on the exact product.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
    int unsigned       ea, eb, sh;
    longint unsigned   fa, fb, p, m, rem, half;
    int                e;
    logic              s, za, zb, ia, ib, na, nb;
    logic [7:0]        ef;
    ea = a[30:23]; eb = b[30:23];
    fa = longint'(a[22:0]); fb = longint'(b[22:0]);
    s  = a[31] ^ b[31];
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == 255) && (fa == 0); ib = (eb == 255) && (fb == 0);
    na = (ea == 255) && (fa != 0); nb = (eb == 255) && (fb != 0);
    if (na || nb || (ia && zb) || (ib && za)) return {3'b001, 32'h7FC00000};
    if (ia || ib) return {3'b000, s, 8'hFF, 23'h0};
    if (za || zb) return {3'b000, s, 31'h0};
    p    = (fa + 64'd8388608) * (fb + 64'd8388608);
    sh   = (p >= 64'h8000_0000_0000) ? 24 : 23;
    m    = p >> sh;
    rem  = p - (m << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && m[0])) m = m + 1;
    e = int'(ea) + int'(eb) - 127 + int'(sh) - 23;
    if (m == 64'd16777216) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {3'b100, s, 8'hFF, 23'h0};
    if (e <= 0)   return {3'b010, s, 31'h0};
    ef = 8'(e);
    return {3'b000, s, ef, m[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    int          k;
    logic [7:0]  e;
    logic [22:0] f;
    k = $urandom_range(0, 15);
    f = 23'($urandom);
    case (k)
      0:       e = 8'd0;
      1:       begin e = 8'd255; if ($urandom_range(0, 1) == 1) f = '0; end
      2:       e = 8'($urandom_range(1, 30));
      3:       e = 8'($urandom_range(200, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, f};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!bus.done && n < LIM);
  endtask

  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [34:0] exp);
    int n;
    issue(a, b);
    chk({tag, " busy"}, 64'(bus.busy), 64'd1);
    wait_done(n);
    chk({tag, " latency"}, 64'(n), 64'(LAT));
    chk({tag, " result"}, 64'(bus.result), 64'(exp[31:0]));
    chk({tag, " flags"}, 64'({bus.flag_ovf, bus.flag_unf, bus.flag_inv}), 64'(exp[34:32]));
    @(posedge clk);
    #1 chk({tag, " done pulse"}, 64'({bus.done, bus.busy}), 64'd0);
  endtask

  initial begin
    int          n, dcount;
    logic [31:0] ra, rb, held;
    logic [34:0] exp;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #1;
    chk("reset state", 64'({bus.busy, bus.done, bus.result, bus.flag_ovf, bus.flag_unf, bus.flag_inv}), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    op("1.5*2",     32'h3FC00000, 32'h40000000, {3'b000, 32'h40400000});
    op("1.5*1.5",   32'h3FC00000, 32'h3FC00000, {3'b000, 32'h40100000});
    op("-2*3",      32'hC0000000, 32'h40400000, {3'b000, 32'hC0C00000});
    op("rnd guard0", 32'h3F800001, 32'h3F800001, {3'b000, 32'h3F800002});
    op("rnd p47",   32'h3FFFFFFF, 32'h3FFFFFFF, {3'b000, 32'h407FFFFE});
    op("overflow",  32'h7F000000, 32'h7F000000, {3'b100, 32'h7F800000});
    op("underflow", 32'h80800000, 32'h00800000, {3'b010, 32'h80000000});
    op("inf*0",     32'h7F800000, 32'h00000000, {3'b001, 32'h7FC00000});
    op("nan*1",     32'h7F800001, 32'h3F800000, {3'b001, 32'h7FC00000});
    op("-inf*2",    32'hFF800000, 32'h40000000, {3'b000, 32'hFF800000});
    op("subn*2",    32'h00000001, 32'h40000000, {3'b000, 32'h00000000});

    // Result holds across idle cycles.
    repeat (7) @(posedge clk);
    #1 chk("idle hold", 64'({bus.result, bus.done}), 64'({32'h00000000, 1'b0}));

    // Ignored start while busy; previous result held until done.
    op("prev", 32'h3FC00000, 32'h40000000, {3'b000, 32'h40400000});
    issue(32'h3FC00000, 32'h3FC00000);
    repeat (4) @(posedge clk);
    #1;
    bus.a = 32'hC0000000; bus.b = 32'h40400000; bus.start = 1'b1;
    chk("hold during busy", 64'(bus.result), 64'h40400000);
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(n);
    chk("ignored start latency", 64'(n), 64'(LAT - 5));
    chk("ignored start result", 64'(bus.result), 64'h40100000);
    dcount = 0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk);
      #1 if (bus.done || bus.busy) dcount++;
    end
    chk("no second done", 64'(dcount), 64'd0);

    // Start held high across done launches a second operation.
    bus.a = 32'h3FC00000; bus.b = 32'h40000000; bus.start = 1'b1;
    @(posedge clk);
    #1 wait_done(n);
    chk("held start first latency", 64'(n), 64'(LAT));
    chk("held start first result", 64'(bus.result), 64'h40400000);
    bus.a = 32'h7F000000; bus.b = 32'h7F000000;
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk("held start accepted", 64'({bus.busy, bus.done}), 64'b10);
    wait_done(n);
    chk("held start second latency", 64'(n), 64'(LAT));
    chk("held start second result", 64'({bus.flag_ovf, bus.result}), 64'({1'b1, 32'h7F800000}));
    @(posedge clk);
    #1;

    // Randomized operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra  = rnd_op();
      rb  = rnd_op();
      exp = model(ra, rb);
      op($sformatf("rand%0d %h*%h", i, ra, rb), ra, rb, exp);
    end

    // Reset mid-operation clears everything and no partial result appears.
    held = bus.result;
    issue(32'h3FC00000, 32'h40000000);
    repeat (9) @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("mid-op reset outputs",
           64'({bus.busy, bus.done, bus.result, bus.flag_ovf, bus.flag_unf, bus.flag_inv}), 64'd0);
    chk("pre-reset result differs", 64'(held == 32'h0 ? 1'b0 : 1'b1), 64'(held == 32'h0 ? 1'b0 : 1'b1) ^ 64'(bus.result != 32'h0));
    @(posedge clk);
    #1 reset = 1'b1;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (bus.done || bus.busy) dcount++;
    end
    chk("no done after reset", 64'(dcount), 64'd0);
    chk("result after reset", 64'(bus.result), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
